// File: rtl/mem_scrub_engine.sv
// Read-back scrubber: walks NUM_BANKS one-hot RAM banks, compares against an address-derived
// pattern and reports mismatches on a valid/ready port. Define MEM_SCRUB_CORRECT_EN for write-back.
module mem_scrub_engine #(
  parameter int NUM_BANKS = 20,
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 16,
  parameter int READ_LAT  = 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_start,
  input  logic                         i_stop,
  input  logic                         i_loop,
  input  logic [1:0]                   i_mode,
  input  logic [DATA_W-1:0]            i_pattern,
  output logic                         o_busy,
  output logic                         o_done,
  output logic [NUM_BANKS-1:0]         o_mem_cs,
  output logic [ADDR_W-1:0]            o_mem_addr,
  input  logic [DATA_W-1:0]            i_mem_data,
  output logic                         o_err_valid,
  input  logic                         i_err_ready,
  output logic [$clog2(NUM_BANKS)-1:0] o_err_bank,
  output logic [ADDR_W-1:0]            o_err_addr,
  output logic [DATA_W-1:0]            o_err_syn,
  output logic [CNT_W-1:0]             o_err_count,
  output logic [CNT_W-1:0]             o_pass_count,
  output logic                         o_mem_we,
  output logic [DATA_W-1:0]            o_mem_wdata
);

  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int WAIT_W = (READ_LAT > 2) ? $clog2(READ_LAT) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_REPORT = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
`ifdef MEM_SCRUB_CORRECT_EN
  localparam logic [2:0] S_WRITE  = 3'd6;
`endif

  logic [2:0]        state;
  logic [BANK_W-1:0] bank;
  logic [ADDR_W-1:0] addr;
  logic              loop_q;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] pattern_q;
  logic              stop_pend;
  logic [WAIT_W-1:0] wait_cnt;
  logic              err_valid;
  logic [BANK_W-1:0] err_bank;
  logic [ADDR_W-1:0] err_addr;
  logic [DATA_W-1:0] err_syn;
  logic [CNT_W-1:0]  err_count;
  logic [CNT_W-1:0]  pass_count;

  logic [2:0]        adv_state;
  logic [BANK_W-1:0] adv_bank;
  logic [ADDR_W-1:0] adv_addr;
  logic              last_loc;
  logic              stop_req;
  logic              cs_active;
  logic [DATA_W-1:0] rd_syn;

  function automatic logic [DATA_W-1:0] exp_val(input logic [1:0]        mode,
                                                input logic [DATA_W-1:0] pat,
                                                input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] a_ext;
    a_ext = DATA_W'(a);
    case (mode)
      2'd0:    exp_val = pat;
      2'd1:    exp_val = a[0] ? ~pat : pat;
      2'd2:    exp_val = a_ext ^ pat;
      default: exp_val = ~(a_ext ^ pat);
    endcase
  endfunction

  assign last_loc = (bank == BANK_W'(NUM_BANKS - 1)) && (addr == '1);
  assign stop_req = stop_pend | i_stop;
  assign rd_syn   = i_mem_data ^ exp_val(mode_q, pattern_q, addr);

  // Where the scan goes once the current location is finished with.
  always_comb begin
    // NOTE: every variable gets a default before any condition, so no latch is inferred.
    adv_state = S_ISSUE;
    adv_bank  = bank;
    adv_addr  = addr + ADDR_W'(1);
    if (addr == '1) adv_bank = bank + BANK_W'(1);
    if (last_loc) begin
      adv_state = S_DONE;
      adv_bank  = '0;
    end
    if (stop_req) adv_state = S_IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
      state      <= S_IDLE;
      bank       <= '0;
      addr       <= '0;
      loop_q     <= 1'b0;
      mode_q     <= '0;
      pattern_q  <= '0;
      stop_pend  <= 1'b0;
      wait_cnt   <= '0;
      err_valid  <= 1'b0;
      err_bank   <= '0;
      err_addr   <= '0;
      err_syn    <= '0;
      err_count  <= '0;
      pass_count <= '0;
    end else begin
      if (state != S_IDLE && i_stop) stop_pend <= 1'b1;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            loop_q     <= i_loop;
            mode_q     <= i_mode;
            pattern_q  <= i_pattern;
            err_count  <= '0;
            pass_count <= '0;
            bank       <= '0;
            addr       <= '0;
            stop_pend  <= 1'b0;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (READ_LAT > 1) begin
            wait_cnt <= WAIT_W'(READ_LAT - 2);
            state    <= S_WAIT;
          end else begin
            state <= S_CHECK;
          end
        end
        S_WAIT: begin
          if (wait_cnt == '0) state <= S_CHECK;
          else                wait_cnt <= wait_cnt - WAIT_W'(1);
        end
        S_CHECK: begin
          if (rd_syn != '0) begin
            err_valid <= 1'b1;
            err_bank  <= bank;
            err_addr  <= addr;
            err_syn   <= rd_syn;
            if (err_count != '1) err_count <= err_count + CNT_W'(1);
            state <= S_REPORT;
          end else begin
            state <= adv_state;
            bank  <= adv_bank;
            addr  <= adv_addr;
            if (stop_req) stop_pend <= 1'b0;
          end
        end
        S_REPORT: begin
          if (i_err_ready) begin
            err_valid <= 1'b0;
`ifdef MEM_SCRUB_CORRECT_EN
            state <= S_WRITE;
`else
            state <= adv_state;
            bank  <= adv_bank;
            addr  <= adv_addr;
            if (stop_req) stop_pend <= 1'b0;
`endif
          end
        end
`ifdef MEM_SCRUB_CORRECT_EN
        S_WRITE: begin
          state <= adv_state;
          bank  <= adv_bank;
          addr  <= adv_addr;
          if (stop_req) stop_pend <= 1'b0;
        end
`endif
        S_DONE: begin
          if (pass_count != '1) pass_count <= pass_count + CNT_W'(1);
          if (loop_q) begin
            state <= S_ISSUE;
          end else begin
            state     <= S_IDLE;
            stop_pend <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MEM_SCRUB_CORRECT_EN
  assign cs_active   = (state == S_ISSUE) || (state == S_WAIT) || (state == S_WRITE);
  assign o_mem_we    = (state == S_WRITE);
  assign o_mem_wdata = (state == S_WRITE) ? exp_val(mode_q, pattern_q, addr) : '0;
`else
  assign cs_active   = (state == S_ISSUE) || (state == S_WAIT);
  assign o_mem_we    = 1'b0;
  assign o_mem_wdata = '0;
`endif

  assign o_mem_cs     = cs_active ? (NUM_BANKS'(1) << bank) : '0;
  assign o_mem_addr   = addr;
  assign o_busy       = (state != S_IDLE);
  assign o_done       = (state == S_DONE);
  assign o_err_valid  = err_valid;
  assign o_err_bank   = err_bank;
  assign o_err_addr   = err_addr;
  assign o_err_syn    = err_syn;
  assign o_err_count  = err_count;
  assign o_pass_count = pass_count;

endmodule

// File: tb/tb_mem_scrub_engine.sv
// Directed bench for mem_scrub_engine: 2 banks x 16 locations, one READ_LAT=1 and one READ_LAT=2 instance.
// Building with +define+MEM_SCRUB_CORRECT_EN adds the write-back scenario.
`timescale 1ns/1ps
module tb_mem_scrub_engine;
  localparam int NB = 2;
  localparam int AW = 4;
`ifdef MEM_SCRUB_CORRECT_EN
  localparam int WR_EXTRA = 1;
`else
  localparam int WR_EXTRA = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // instance 1 (READ_LAT=1)
  logic        start, stop, loop_en, err_ready;
  logic [1:0]  mode;
  logic [7:0]  pattern;
  logic        busy, done, err_valid, mem_we;
  logic [1:0]  mem_cs;
  logic [3:0]  mem_addr, err_addr;
  logic [7:0]  mem_data, mem_wdata, err_syn;
  logic        err_bank;
  logic [15:0] err_count, pass_count;

  // instance 2 (READ_LAT=2)
  logic        start2, stop2, loop2, ready2;
  logic [1:0]  mode2;
  logic [7:0]  pattern2;
  logic        busy2, done2, err_valid2, mem_we2;
  logic [1:0]  mem_cs2;
  logic [3:0]  mem_addr2, err_addr2;
  logic [7:0]  mem_data2, mem_wdata2, err_syn2, rd2_a;
  logic        err_bank2;
  logic [15:0] err_count2, pass_count2;

  mem_scrub_engine #(.NUM_BANKS(NB), .ADDR_W(AW), .DATA_W(8), .CNT_W(16), .READ_LAT(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop), .i_loop(loop_en),
    .i_mode(mode), .i_pattern(pattern), .o_busy(busy), .o_done(done), .o_mem_cs(mem_cs),
    .o_mem_addr(mem_addr), .i_mem_data(mem_data), .o_err_valid(err_valid), .i_err_ready(err_ready),
    .o_err_bank(err_bank), .o_err_addr(err_addr), .o_err_syn(err_syn), .o_err_count(err_count),
    .o_pass_count(pass_count), .o_mem_we(mem_we), .o_mem_wdata(mem_wdata)
  );

  mem_scrub_engine #(.NUM_BANKS(NB), .ADDR_W(AW), .DATA_W(8), .CNT_W(16), .READ_LAT(2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start2), .i_stop(stop2), .i_loop(loop2),
    .i_mode(mode2), .i_pattern(pattern2), .o_busy(busy2), .o_done(done2), .o_mem_cs(mem_cs2),
    .o_mem_addr(mem_addr2), .i_mem_data(mem_data2), .o_err_valid(err_valid2), .i_err_ready(ready2),
    .o_err_bank(err_bank2), .o_err_addr(err_addr2), .o_err_syn(err_syn2), .o_err_count(err_count2),
    .o_pass_count(pass_count2), .o_mem_we(mem_we2), .o_mem_wdata(mem_wdata2)
  );

  // Shared memory contents; instance 1 may write it back, instance 2 only reads.
  logic [7:0] mem [NB][16];
  logic       fill, poke;
  logic [1:0] fill_mode;
  logic [7:0] fill_pat, poke_val;
  logic       poke_bank;
  logic [3:0] poke_addr;

  function automatic logic [7:0] fill_val(input logic [1:0] m, input logic [7:0] p, input logic [3:0] a);
    case (m)
      2'd0:    return p;
      2'd1:    return a[0] ? ~p : p;
      2'd2:    return {4'h0, a} ^ p;
      default: return ~({4'h0, a} ^ p);
    endcase
  endfunction

  function automatic logic [7:0] lookup(input logic [1:0] cs, input logic [3:0] a);
    if (cs == 2'b01) return mem[0][a];
    if (cs == 2'b10) return mem[1][a];
    return 8'hEE;
  endfunction

  always @(posedge clk) begin
    if (fill) begin
      for (int b = 0; b < NB; b++)
        for (int a = 0; a < 16; a++)
          mem[b][a] <= fill_val(fill_mode, fill_pat, 4'(a));
    end else if (poke) begin
      mem[poke_bank][poke_addr] <= poke_val;
    end else if (mem_we) begin
      if (mem_cs == 2'b01) mem[0][mem_addr] <= mem_wdata;
      else if (mem_cs == 2'b10) mem[1][mem_addr] <= mem_wdata;
    end
  end

  always @(posedge clk) mem_data <= lookup(mem_cs, mem_addr);

  always @(posedge clk) begin
    rd2_a     <= lookup(mem_cs2, mem_addr2);
    mem_data2 <= rd2_a;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_mem(input logic [1:0] m, input logic [7:0] p);
    fill_mode = m;
    fill_pat  = p;
    fill      = 1'b1;
    tick();
    fill      = 1'b0;
  endtask

  task automatic poke_mem(input logic b, input logic [3:0] a, input logic [7:0] v);
    poke_bank = b;
    poke_addr = a;
    poke_val  = v;
    poke      = 1'b1;
    tick();
    poke      = 1'b0;
  endtask

  task automatic start_scan(input logic lp, input logic [1:0] m, input logic [7:0] p);
    loop_en = lp;
    mode    = m;
    pattern = p;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  // Results of the last run_pass; cycle 1 is the cycle on entry.
  int         rp_cycles, rp_reports, rp_err_cycle, rp_we_cycle;
  logic       rp_bank;
  logic [3:0] rp_addr, rp_we_addr;
  logic [7:0] rp_syn, rp_we_data;
  logic [1:0] rp_we_cs;

  task automatic run_pass();
    rp_cycles = 1; rp_reports = 0; rp_err_cycle = 0; rp_we_cycle = 0;
    rp_bank = 1'b0; rp_addr = '0; rp_syn = '0; rp_we_addr = '0; rp_we_data = '0; rp_we_cs = '0;
    while (!done && rp_cycles < 400) begin
      if (err_valid && err_ready) begin
        rp_reports++;
        if (rp_err_cycle == 0) begin
          rp_err_cycle = rp_cycles;
          rp_bank = err_bank; rp_addr = err_addr; rp_syn = err_syn;
        end
      end
      if ((mem_we || mem_wdata != 8'h00) && rp_we_cycle == 0) begin
        rp_we_cycle = rp_cycles;
        rp_we_cs = mem_cs; rp_we_addr = mem_addr; rp_we_data = mem_wdata;
      end
      tick();
      rp_cycles++;
    end
  endtask

  int   cyc, errs;
  logic flag, saw_done;

  initial begin
    start = 0; stop = 0; loop_en = 0; err_ready = 1; mode = 0; pattern = 0;
    start2 = 0; stop2 = 0; loop2 = 0; ready2 = 1; mode2 = 0; pattern2 = 0;
    fill = 0; poke = 0; fill_mode = 0; fill_pat = 0; poke_val = 0; poke_bank = 0; poke_addr = 0;

    // Reset state
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cs", mem_cs, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_err_valid", err_valid, 0);
    check("rst_err_count", err_count, 0);
    check("rst_pass_count", pass_count, 0);
    check("rst_we", mem_we, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

    // Clean pass, mode 0 / 0x55
    fill_mem(2'd0, 8'h55);
    start_scan(1'b0, 2'd0, 8'h55);
    check("p0_busy", busy, 1);
    check("p0_first_cs", mem_cs, 2'b01);
    check("p0_first_addr", mem_addr, 0);
    run_pass();
    check("p0_done_cycle", rp_cycles, 65);
    check("p0_reports", rp_reports, 0);
    check("p0_no_write", rp_we_cycle, 0);
    tick();
    check("p0_err_count", err_count, 0);
    check("p0_pass_count", pass_count, 1);
    check("p0_idle", busy, 0);

    // Single error at bank 1 addr 3, ready always high
    poke_mem(1'b1, 4'h3, 8'h57);
    err_ready = 1'b1;
    start_scan(1'b0, 2'd0, 8'h55);
    run_pass();
    check("e1_reports", rp_reports, 1);
    check("e1_err_cycle", rp_err_cycle, 41);
    check("e1_bank", rp_bank, 1);
    check("e1_addr", rp_addr, 3);
    check("e1_syn", rp_syn, 8'h02);
    check("e1_done_cycle", rp_cycles, 66 + WR_EXTRA);
`ifndef MEM_SCRUB_CORRECT_EN
    check("e1_no_write", rp_we_cycle, 0);
`endif
    tick();
    check("e1_err_count", err_count, 1);
    check("e1_pass_count", pass_count, 1);

    // Same error with back-pressure for 10 cycles
    poke_mem(1'b1, 4'h3, 8'h57);
    err_ready = 1'b0;
    start_scan(1'b0, 2'd0, 8'h55);
    cyc = 1;
    while (!err_valid && cyc < 100) begin tick(); cyc++; end
    check("st_valid_cycle", cyc, 41);
    flag = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!(err_valid && err_bank == 1'b1 && err_addr == 4'h3 && err_syn == 8'h02 &&
            mem_cs == 2'b00 && busy)) flag = 1'b0;
      tick();
    end
    check("st_fields_stable_cs_low", flag, 1);
    err_ready = 1'b1;
    tick();
    check("st_valid_cleared", err_valid, 0);
    check("st_resume_cs", mem_cs, 2'b10);
    check("st_resume_addr", mem_addr, 4'h4);
    run_pass();
    check("st_no_more_reports", rp_reports, 0);
    tick();
    check("st_err_count", err_count, 1);

    // Mode 2, clean
    fill_mem(2'd2, 8'h0F);
    start_scan(1'b0, 2'd2, 8'h0F);
    run_pass();
    check("m2_reports", rp_reports, 0);
    check("m2_done_cycle", rp_cycles, 65);
    tick();

    // Mode 3 with one flipped MSB at bank 0 addr 5 (expected 0xCA)
    fill_mem(2'd3, 8'h30);
    poke_mem(1'b0, 4'h5, 8'h4A);
    start_scan(1'b0, 2'd3, 8'h30);
    run_pass();
    check("m3_reports", rp_reports, 1);
    check("m3_err_cycle", rp_err_cycle, 13);
    check("m3_bank", rp_bank, 0);
    check("m3_addr", rp_addr, 5);
    check("m3_syn", rp_syn, 8'h80);
    tick();

    // READ_LAT=2 instance, mode 1 checkerboard 0xA5
    fill_mem(2'd1, 8'hA5);
    mode2 = 2'd1; pattern2 = 8'hA5; loop2 = 1'b0; ready2 = 1'b1;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    cyc = 1; errs = 0;
    while (!done2 && cyc < 400) begin
      if (err_valid2) errs++;
      tick();
      cyc++;
    end
    check("l2_done_cycle", cyc, 97);
    check("l2_errors", errs, 0);
    tick();
    check("l2_pass_count", pass_count2, 1);
    check("l2_idle", busy2, 0);

    // Loop, then stop (with a simultaneous start) partway through pass 2
    fill_mem(2'd0, 8'h55);
    start_scan(1'b1, 2'd0, 8'h55);
    run_pass();
    check("lp_pass1_cycle", rp_cycles, 65);
    tick();
    check("lp_pass_count", pass_count, 1);
    check("lp_still_busy", busy, 1);
    for (int i = 0; i < 19; i++) tick();
    stop = 1'b1; start = 1'b1;
    tick();
    stop = 1'b0; start = 1'b0;
    cyc = 0; saw_done = 1'b0;
    while (busy && cyc < 6) begin
      if (done) saw_done = 1'b1;
      tick();
      cyc++;
    end
    check("lp_stopped", busy, 0);
    check("lp_no_done", saw_done, 0);
    check("lp_pass_kept", pass_count, 1);
    for (int i = 0; i < 3; i++) tick();
    check("lp_start_ignored", busy, 0);

    // Start and stop together in IDLE: start wins, full pass runs
    loop_en = 1'b0; mode = 2'd0; pattern = 8'h55;
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    run_pass();
    check("ss_full_pass", rp_cycles, 65);
    tick();
    check("ss_pass_count", pass_count, 1);

    // Reset during an outstanding report
    poke_mem(1'b1, 4'h3, 8'h57);
    err_ready = 1'b0;
    start_scan(1'b0, 2'd0, 8'h55);
    cyc = 1;
    while (!err_valid && cyc < 100) begin tick(); cyc++; end
    check("rs_valid_seen", err_valid, 1);
    rst_n = 1'b0;
    #1;
    check("rs_valid_lost", err_valid, 0);
    check("rs_idle", busy, 0);
    check("rs_err_count", err_count, 0);
    tick();
    rst_n = 1'b1;
    err_ready = 1'b1;
    tick();

`ifdef MEM_SCRUB_CORRECT_EN
    // Write-back: pass 1 repairs, pass 2 is clean
    fill_mem(2'd0, 8'h55);
    poke_mem(1'b1, 4'h3, 8'h57);
    start_scan(1'b1, 2'd0, 8'h55);
    run_pass();
    check("cr_p1_reports", rp_reports, 1);
    check("cr_p1_we_cycle", rp_we_cycle, 42);
    check("cr_p1_we_data", rp_we_data, 8'h55);
    check("cr_p1_we_cs", rp_we_cs, 2'b10);
    check("cr_p1_we_addr", rp_we_addr, 4'h3);
    check("cr_p1_done_cycle", rp_cycles, 67);
    tick();
    run_pass();
    check("cr_p2_reports", rp_reports, 0);
    check("cr_p2_done_cycle", rp_cycles, 65);
    tick();
    check("cr_err_count", err_count, 1);
    check("cr_pass_count", pass_count, 2);
    check("cr_mem_fixed", mem[1][3], 8'h55);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    cyc = 0;
    while (busy && cyc < 6) begin tick(); cyc++; end
    check("cr_stopped", busy, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
